fxp_booth_multiplier_param: RTL and testbench

Parametrised sequential radix-4 (modified Booth) signed fixed-point multiplier; next generation of the 16-bit Q-format multiplier in the fixed-point arithmetic library.
- Generalised in operand width and fractional-bit count.
- Adds a busy indication, well-defined restart/abort and correct handling of the most-negative operand.
- Consumed by the ODE solver datapath wherever a product of two Q-format values is needed.

---
 rtl/fxp_booth_multiplier_param.sv | 115 +++++++++++
 tb/tb_fxp_booth_multiplier_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_booth_multiplier_param.sv
// Sequential radix-4 (modified Booth) signed Q-format multiplier, WIDTH/2 cycles per product.
// Optional build macro FXP_MUL_SATURATE_EN clamps the result on overflow instead of wrapping.
module fxp_booth_multiplier_param #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             busy,
  output logic             finish
);

  localparam int STEPS = WIDTH / 2;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [2*WIDTH-1:0] RND = ({{(2*WIDTH-1){1'b0}}, 1'b1} << FRAC) >> 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Handshake: start is level-sampled; only a registered 0->1 transition is a request.
  // finish stays high (with result/overflow_flag valid) until the next accepted start.
  state_t           state;
  logic             start_q;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH+1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             acc_q1;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [2:0]       window;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] m2;
  logic [WIDTH+1:0] pp;
  logic [WIDTH+1:0] sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] rounded;
  logic [WIDTH-FRAC:0] hi_bits;
  logic             ovf_cond;
  logic             unused_bits;

  assign accept = start & ~start_q;
  assign window = {acc_lo[1:0], acc_q1};
  // Two guard bits keep -M and -2M exact even for the most negative multiplicand.
  assign m_ext  = {{2{mcand[WIDTH-1]}}, mcand};
  assign m2     = {mcand[WIDTH-1], mcand, 1'b0};

  always_comb begin
    pp = '0;
    case (window)
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m2;
      3'b100:         pp = -m2;
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
  end

  assign sum = acc_hi + pp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      acc_q1  <= 1'b0;
      cnt     <= '0;
    end else begin
      start_q <= start;
      if (accept) begin
        state  <= RUN;
        mcand  <= multiplicand;
        acc_hi <= '0;
        acc_lo <= multiplier;
        acc_q1 <= 1'b0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc_hi <= {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
        acc_lo <= {sum[1:0], acc_lo[WIDTH-1:2]};
        acc_q1 <= acc_lo[1];
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(STEPS - 1)) state <= DONE;
      end
    end
  end

  assign busy   = (state == RUN);
  assign finish = (state == DONE);

  // After WIDTH/2 shifts the full signed product sits in the low part of the accumulator.
  assign prod     = {acc_hi[WIDTH-1:0], acc_lo};
  assign rounded  = prod + RND;
  assign hi_bits  = rounded[2*WIDTH-1:WIDTH+FRAC-1];
  assign ovf_cond = ~((&hi_bits) | ~(|hi_bits));
  assign overflow_flag = finish & ovf_cond;

`ifdef FXP_MUL_SATURATE_EN
  always_comb begin
    result = rounded[WIDTH+FRAC-1:FRAC];
    if (ovf_cond)
      result = rounded[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign result = rounded[WIDTH+FRAC-1:FRAC];
`endif

  assign unused_bits = ^{rounded, acc_hi, state};

endmodule

// File: tb/tb_fxp_booth_multiplier_param.sv
// Directed bench for fxp_booth_multiplier_param at WIDTH=16, FRAC=7.
module tb_fxp_booth_multiplier_param;

  localparam int WIDTH = 16;
  localparam int FRAC  = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] result;
  logic             overflow_flag;
  logic             busy;
  logic             finish;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  fxp_booth_multiplier_param #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .result        (result),
    .overflow_flag (overflow_flag),
    .busy          (busy),
    .finish        (finish)
  );

  // driver tasks
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_finish(output int cycles);
    cycles = 0;
    while (!finish && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_res, input logic exp_ovf);
    int cyc;
    launch(a, b);
    n_checks++;
    if (busy !== 1'b1 || finish !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: busy=%b finish=%b, required busy=1 finish=0", name, busy, finish);
    end
    wait_finish(cyc);
    n_checks++;
    if (cyc !== 8) begin
      n_fail++;
      $display("FAIL %s_latency: %0d cycles, required 8", name, cyc);
    end
    n_checks++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL %s_result: got %h, required %h", name, result, exp_res);
    end
    n_checks++;
    if (overflow_flag !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s_overflow: got %b, required %b", name, overflow_flag, exp_ovf);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_at_finish: got %b, required 0", name, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (finish !== 1'b1 || result !== exp_res) begin
      n_fail++;
      $display("FAIL %s_hold: finish=%b result=%h, required finish=1 result=%h", name, finish, result, exp_res);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || finish !== 1'b0 || result !== '0 || overflow_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b finish=%b result=%h ovf=%b, required all 0",
               busy, finish, result, overflow_flag);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    test_op("one_x_one",   16'h0080, 16'h0080, 16'h0080, 1'b0);
    test_op("neg_x_two",   16'hFF40, 16'h0100, 16'hFE80, 1'b0);
    test_op("round_up",    16'h0001, 16'h0040, 16'h0001, 1'b0);
    test_op("round_down",  16'h0001, 16'h003F, 16'h0000, 1'b0);
  endtask

  task automatic test_extremes();
    logic [WIDTH-1:0] exp_mn, exp_mx;
`ifdef FXP_MUL_SATURATE_EN
    exp_mn = 16'h7FFF;
    exp_mx = 16'h7FFF;
`else
    exp_mn = 16'h0000;
    exp_mx = 16'hFE00;
`endif
    test_op("minneg_x_one", 16'h8000, 16'h0080, 16'h8000, 1'b0);
    test_op("minneg_sq",    16'h8000, 16'h8000, exp_mn,   1'b1);
    test_op("maxpos_sq",    16'h7FFF, 16'h7FFF, exp_mx,   1'b1);
  endtask

  task automatic test_held_start();
    int   rises;
    logic prev;
    @(negedge clk);
    multiplicand = 16'h0100;
    multiplier   = 16'h0100;
    start        = 1'b1;
    rises        = 0;
    prev         = finish;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (finish && !prev) rises++;
      prev = finish;
    end
    n_checks++;
    if (rises !== 1) begin
      n_fail++;
      $display("FAIL held_start_finishes: %0d finish pulses, required 1", rises);
    end
    n_checks++;
    if (finish !== 1'b1 || result !== 16'h0200) begin
      n_fail++;
      $display("FAIL held_start_result: finish=%b result=%h, required finish=1 result=0200", finish, result);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_restart();
    int cyc;
    launch(16'h0080, 16'h0080);
    repeat (2) @(posedge clk);
    #1;
    multiplicand = 16'h0180;
    multiplier   = 16'h0100;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_finish(cyc);
    n_checks++;
    if (cyc !== 8) begin
      n_fail++;
      $display("FAIL restart_latency: %0d cycles after second edge, required 8", cyc);
    end
    n_checks++;
    if (result !== 16'h0300 || overflow_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_result: result=%h ovf=%b, required 0300 / 0", result, overflow_flag);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    int cyc;
    launch(16'h0100, 16'h0300);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || finish !== 1'b0 || result !== '0 || overflow_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_run: busy=%b finish=%b result=%h ovf=%b, required all 0",
               busy, finish, result, overflow_flag);
    end
    @(posedge clk);
    #2;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (finish) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL no_finish_after_reset: finish high %0d cycles, required 0", seen);
    end
    // reset while a nonzero result is being presented
    test_op("pre_reset_op", 16'h7FFF, 16'h7FFF,
`ifdef FXP_MUL_SATURATE_EN
            16'h7FFF,
`else
            16'hFE00,
`endif
            1'b1);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (finish !== 1'b0 || result !== '0 || overflow_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_done: finish=%b result=%h ovf=%b, required all 0",
               finish, result, overflow_flag);
    end
    // start already high at reset release counts as a fresh request
    multiplicand = 16'h0080;
    multiplier   = 16'hFF80;
    start        = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    wait_finish(cyc);
    n_checks++;
    if (cyc !== 9 || result !== 16'hFF80 || overflow_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL start_high_at_release: cycles=%0d result=%h ovf=%b, required 9 / ff80 / 0",
               cyc, result, overflow_flag);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_held_start();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
